hamming_enc_inj: RTL and testbench
==================================

HAMMING_ENC_INJ -- requirements
Module: hamming_enc_inj

Interface
REQ-001 The block SHALL provide parameter K, default 4, meaning data width in bits; legal values are 4, 11, 26 and 57.
REQ-002 The block SHALL derive localparam R = smallest r with 2^r >= K+r+1, N = K+R and CW = N (+1 when HAMMING_SECDED_EN is defined).
REQ-003 The block SHALL provide parameter CNTW, default 16, meaning the width of the injection counter.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit: input word offered.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept a word.
REQ-008 The block SHALL have port in_data, input, K bits: data word, with d0 = in_data[0].
REQ-009 The block SHALL have port inj_mode, input, 2 bits: 0 none, 1 fixed, 2 walking, 3 reserved (treated as none).
REQ-010 The block SHALL have port inj_pos, input, 6 bits: fixed flip position 1..CW; 0 or >CW means no flip.
REQ-011 The block SHALL have port out_valid, output, 1 bit: codeword held.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer takes the word.
REQ-013 The block SHALL have port out_code, output, CW bits: codeword; position p (1-based) is out_code[p-1].
REQ-014 The block SHALL have port inj_count, output, CNTW bits: number of words emitted with a flipped bit, saturating.

Function
REQ-015 Codeword layout SHALL place parity at positions 2^i and data bits d0..dK-1 in ascending order at the remaining positions 1..N.
REQ-016 Parity at position 2^i SHALL be the XOR of all data positions whose index has bit i set; for K=4 this gives p1=d0^d1^d3, p2=d0^d2^d3, p4=d1^d2^d3.
REQ-017 A transfer SHALL occur on a cycle where in_valid && in_ready; the encoded, injected word SHALL be registered into out_code and out_valid set on the next edge, giving 1-cycle latency.
REQ-018 in_ready SHALL equal !out_valid || out_ready, so that accept and drain can happen in the same cycle with no bubble at full throughput.
REQ-019 out_code and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-020 out_valid SHALL clear on an edge where out_ready is high and no new transfer occurs.
REQ-021 Fixed mode SHALL invert out_code[inj_pos-1] of each accepted word when 1 <= inj_pos <= CW.
REQ-022 Walking mode SHALL keep an internal position register wpos, starting at 1, flip position wpos, and advance wpos after each accepted word, wrapping from CW back to 1.
REQ-023 wpos SHALL reset to 1 on any accepted word whose inj_mode is not 2.
REQ-024 inj_mode and inj_pos SHALL be sampled only on the transfer cycle.
REQ-025 inj_count SHALL increment by 1 per transfer that flips a bit and SHALL saturate at all-ones.

Reset
REQ-026 While reset_n is 0 at a clock edge: out_valid=0, out_code=0, inj_count=0, wpos=1.
REQ-027 in_ready SHALL be 1 during and after reset.
REQ-028 Reset mid-stream SHALL discard any held word without emitting it.

Configuration
REQ-029 With macro HAMMING_SECDED_EN defined, CW=N+1 and out_code[N] SHALL be the even overall parity of bits N-1..0, computed before injection.
REQ-030 With HAMMING_SECDED_EN defined, position N+1 SHALL be a legal injection target for both fixed and walking modes.
REQ-031 Without HAMMING_SECDED_EN, CW=N and the block SHALL be pure SEC Hamming.

Verification
REQ-032 K=4, mode 0, in_data=4'b1011 -> out_code=7'h55 one cycle later; with SECDED, 8'h55.
REQ-033 K=4, mode 1, inj_pos=3, in_data=0 -> out_code=7'h04, inj_count=1; inj_pos=0 -> 7'h00, count unchanged.
REQ-034 K=4, mode 2, four back-to-back zero words with out_ready=1 -> 7'h01, 7'h02, 7'h04, 7'h08 on consecutive cycles; the 8th word wraps back to 7'h01.
REQ-035 out_ready=0 for 3 cycles with a word held -> in_ready=0, out_code stable; release -> next word follows with no gap.
REQ-036 reset_n=0 for one edge mid-stream in mode 2 -> out_valid=0, inj_count=0, next walking flip at position 1.
REQ-037 CNTW=2, mode 1, 5 words -> inj_count saturates at 3.

Source files
------------

// File: rtl/hamming_enc_inj.sv
// Hamming SEC encoder with a one-deep valid/ready output register and error injection.
// Define HAMMING_SECDED_EN to append an overall even-parity bit (SECDED codeword).
module hamming_enc_inj #(
  parameter int K    = 4,
  parameter int CNTW = 16,
  localparam int R = ((2**2) >= (K + 3)) ? 2 :
                     ((2**3) >= (K + 4)) ? 3 :
                     ((2**4) >= (K + 5)) ? 4 :
                     ((2**5) >= (K + 6)) ? 5 :
                     ((2**6) >= (K + 7)) ? 6 : 7,
  localparam int N = K + R,
`ifdef HAMMING_SECDED_EN
  localparam int CW = N + 1
`else
  localparam int CW = N
`endif
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [K-1:0]    in_data,
  input  logic [1:0]      inj_mode,
  input  logic [5:0]      inj_pos,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW-1:0]   out_code,
  output logic [CNTW-1:0] inj_count
);

  localparam logic [6:0] CW_P = 7'(CW);

  logic            out_valid_q, out_valid_d;
  logic [CW-1:0]   out_code_q, out_code_d;
  logic [CNTW-1:0] inj_count_q, inj_count_d;
  logic [6:0]      wpos_q, wpos_d;
  logic            xfer_s;
  logic [6:0]      flip_pos_s;
  logic [CW-1:0]   code_s;

  // Data fills the non-power-of-two positions in order; parity 2^i covers every position with bit i set.
  function automatic logic [N-1:0] hamming_encode(input logic [K-1:0] d);
    logic [N-1:0] c;
    logic         par;
    int           di;
    c  = '0;
    di = 0;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[di];
        di = di + 1;
      end
    end
    for (int i = 0; i < R; i++) begin
      par = 1'b0;
      for (int p = 1; p <= N; p++) begin
        if (((p >> i) & 1) == 1) begin
          par = par ^ c[p-1];
        end
      end
      c[(1 << i) - 1] = par;
    end
    return c;
  endfunction

  assign in_ready  = !out_valid_q || out_ready;
  assign xfer_s    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign inj_count = inj_count_q;

  // Select the flip position for the word on offer; 0 means no flip.
  always_comb begin
    flip_pos_s = 7'd0;
    case (inj_mode)
      2'd1: begin
        if (({1'b0, inj_pos} >= 7'd1) && ({1'b0, inj_pos} <= CW_P)) begin
          flip_pos_s = {1'b0, inj_pos};
        end else begin
          flip_pos_s = 7'd0;
        end
      end
      2'd2:    flip_pos_s = wpos_q;
      default: flip_pos_s = 7'd0;
    endcase
  end

  // Encode, add overall parity before injection, then apply the flip.
  always_comb begin
    code_s = '0;
    code_s[N-1:0] = hamming_encode(in_data);
`ifdef HAMMING_SECDED_EN
    code_s[N] = ^code_s[N-1:0];
`endif
    for (int p = 1; p <= CW; p++) begin
      if (flip_pos_s == 7'(p)) begin
        code_s[p-1] = ~code_s[p-1];
      end else begin
        code_s[p-1] = code_s[p-1];
      end
    end
  end

  // Next-state for the output register, walking position and saturating counter.
  always_comb begin
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    inj_count_d = inj_count_q;
    wpos_d      = wpos_q;
    if (xfer_s) begin
      out_valid_d = 1'b1;
      out_code_d  = code_s;
      if (inj_mode == 2'd2) begin
        if (wpos_q >= CW_P) begin
          wpos_d = 7'd1;
        end else begin
          wpos_d = wpos_q + 7'd1;
        end
      end else begin
        wpos_d = 7'd1;
      end
      if ((flip_pos_s != 7'd0) && (inj_count_q != {CNTW{1'b1}})) begin
        inj_count_d = inj_count_q + CNTW'(1);
      end else begin
        inj_count_d = inj_count_q;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      inj_count_q <= '0;
      wpos_q      <= 7'd1;
    end else begin
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      inj_count_q <= inj_count_d;
      wpos_q      <= wpos_d;
    end
  end

endmodule

// File: tb/tb_hamming_enc_inj.sv
// Directed bench for hamming_enc_inj (K=4): a syndrome-based reference model checked every cycle,
// plus literal expectations. A second instance with CNTW=2 checks counter saturation.
module tb_hamming_enc_inj;

`ifdef HAMMING_SECDED_EN
  localparam int CW = 8;
`else
  localparam int CW = 7;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          in_valid = 1'b0;
  logic [3:0]    in_data = 4'd0;
  logic [1:0]    inj_mode = 2'd0;
  logic [5:0]    inj_pos = 6'd0;
  logic          out_ready = 1'b1;
  logic          in_ready, out_valid, in_ready2, out_valid2;
  logic [CW-1:0] out_code, out_code2;
  logic [15:0]   inj_count;
  logic [1:0]    inj_count2;

  int checks = 0;
  int failures = 0;

  hamming_enc_inj #(.K(4), .CNTW(16)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .inj_mode(inj_mode), .inj_pos(inj_pos), .out_valid(out_valid),
    .out_ready(out_ready), .out_code(out_code), .inj_count(inj_count));

  hamming_enc_inj #(.K(4), .CNTW(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .inj_mode(inj_mode), .inj_pos(inj_pos), .out_valid(out_valid2),
    .out_ready(out_ready), .out_code(out_code2), .inj_count(inj_count2));

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: place data, then choose parity so the XOR of all set-bit positions is zero.
  function automatic logic [CW-1:0] ref_code(input logic [3:0] d, input int flip);
    logic [CW-1:0] c;
    int s;
    int di;
    c = '0;
    s = 0;
    di = 0;
    for (int p = 1; p <= 7; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[di];
        if (d[di]) s = s ^ p;
        di++;
      end
    end
    c[0] = s[0];
    c[1] = s[1];
    c[3] = s[2];
`ifdef HAMMING_SECDED_EN
    c[7] = ^c[6:0];
`endif
    if (flip >= 1 && flip <= CW) c[flip-1] = ~c[flip-1];
    return c;
  endfunction

  logic          m_init = 1'b0;
  logic          m_valid;
  logic [CW-1:0] m_code;
  int            m_count;
  int            m_wpos;
  int            m_flip;
  wire           m_ready = !m_valid || out_ready;
  wire           m_xfer = in_valid && m_ready;

  always_comb begin
    m_flip = 0;
    if (inj_mode == 2'd1 && inj_pos >= 6'd1 && int'(inj_pos) <= CW) m_flip = int'(inj_pos);
    else if (inj_mode == 2'd2) m_flip = m_wpos;
  end

  always @(posedge clock) begin
    if (!reset_n) begin
      m_init  <= 1'b1;
      m_valid <= 1'b0;
      m_code  <= '0;
      m_count <= 0;
      m_wpos  <= 1;
    end else if (m_xfer) begin
      m_valid <= 1'b1;
      m_code  <= ref_code(in_data, m_flip);
      if (m_flip != 0) m_count <= m_count + 1;
      m_wpos  <= (inj_mode == 2'd2) ? ((m_wpos == CW) ? 1 : m_wpos + 1) : 1;
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clock) begin
    if (m_init) begin
      check("model_in_ready", 64'(in_ready), 64'(m_ready));
      check("model_out_valid", 64'(out_valid), 64'(m_valid));
      check("model_inj_count", 64'(inj_count), 64'(m_count));
      check("model_inj_count_sat", 64'(inj_count2), 64'((m_count > 3) ? 3 : m_count));
      if (m_valid) begin
        check("model_out_code", 64'(out_code), 64'(m_code));
        check("model_out_code2", 64'(out_code2), 64'(m_code));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [3:0] d, input logic [1:0] m, input logic [5:0] p);
    int waited;
    in_valid = 1'b1;
    in_data  = d;
    inj_mode = m;
    inj_pos  = p;
    waited = 0;
    while (!in_ready && waited < 20) begin
      step();
      waited++;
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    check("pin_model_55", 64'(ref_code(4'b1011, 0)), 64'h55);
    check("pin_model_fix3", 64'(ref_code(4'b0000, 3)), 64'h04);
    check("pin_model_4b", 64'(ref_code(4'b1000, 0)), 64'h4B);

    // Reset
    #2;
    reset_n = 1'b0;
    step();
    step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_code", 64'(out_code), 64'd0);
    check("rst_inj_count", 64'(inj_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    reset_n = 1'b1;
    step();

    // Plain encode, then idle drain
    send(4'b1011, 2'd0, 6'd0);
    check("enc_1011", 64'(out_code), 64'h55);
    check("enc_valid", 64'(out_valid), 64'd1);
    step();
    check("drain_valid", 64'(out_valid), 64'd0);

    // Fixed injection
    send(4'b0000, 2'd1, 6'd3);
    check("fix_pos3", 64'(out_code), 64'h04);
    check("fix_count", 64'(inj_count), 64'd1);
    send(4'b0000, 2'd1, 6'd0);
    check("fix_pos0", 64'(out_code), 64'h00);
    check("fix_pos0_count", 64'(inj_count), 64'd1);

    // Walking injection, eight back-to-back words
    send(4'b0000, 2'd2, 6'd0);
    check("walk_1", 64'(out_code), 64'h01);
    send(4'b0000, 2'd2, 6'd0);
    check("walk_2", 64'(out_code), 64'h02);
    send(4'b0000, 2'd2, 6'd0);
    check("walk_3", 64'(out_code), 64'h04);
    send(4'b0000, 2'd2, 6'd0);
    check("walk_4", 64'(out_code), 64'h08);
    for (int i = 0; i < 4; i++) send(4'b0000, 2'd2, 6'd0);
`ifdef HAMMING_SECDED_EN
    check("walk_8", 64'(out_code), 64'h80);
`else
    check("walk_8_wrap", 64'(out_code), 64'h01);
`endif
    check("walk_count", 64'(inj_count), 64'd9);
    check("sat_count", 64'(inj_count2), 64'd3);

    // Backpressure: hold A for three cycles while B waits
    send(4'b0110, 2'd0, 6'd0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'b1000;
    inj_mode = 2'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_code", 64'(out_code), 64'h33);
      check("stall_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("release_code", 64'(out_code), 64'h4B);
    check("release_valid", 64'(out_valid), 64'd1);

    // Reset mid-stream while walking
    send(4'b0000, 2'd2, 6'd0);
    send(4'b0000, 2'd2, 6'd0);
    send(4'b0000, 2'd2, 6'd0);
    out_ready = 1'b0;
    reset_n = 1'b0;
    step();
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_count", 64'(inj_count), 64'd0);
    reset_n = 1'b1;
    out_ready = 1'b1;
    send(4'b0000, 2'd2, 6'd0);
    check("post_rst_walk", 64'(out_code), 64'h01);
    check("post_rst_count", 64'(inj_count), 64'd1);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
